// File: rtl/pwm_stream_reader.sv
// pwm_stream_reader: streams coefficient pairs from a 2-cycle-read dual-port bank through a credit-limited FIFO
module pwm_stream_reader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW-1:0]    pair_count,
    output logic             ena,
    output logic             enb,
    output logic             wea,
    output logic             web,
    output logic [AW-1:0]    addra,
    output logic [AW-1:0]    addrb,
    input  logic [WIDTH-1:0] douta,
    input  logic [WIDTH-1:0] doutb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_last,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    base_q, base_d, n_q, n_d, i_q, i_d;
    logic             done_q, done_d;
    logic [1:0]       v_q, l_q;
    logic [2*WIDTH:0] mem_q [4];
    logic [1:0]       wp_q, rp_q;
    logic [2:0]       cnt_q;
    logic [2:0]       credit;
    logic             issue, iss_last, push, pop;

    // FIFO occupancy plus reads still travelling through the bank bound the issue window
    assign credit    = cnt_q + {2'b0, v_q[0]} + {2'b0, v_q[1]};
    assign issue     = (state_q == RUN) && (credit < 3'd4);
    assign iss_last  = (i_q == n_q - AW'(1));
    assign push      = v_q[1];
    assign pop       = out_valid & out_ready;
    assign ena       = issue;
    assign enb       = issue;
    assign wea       = 1'b0;
    assign web       = 1'b0;
    assign addra     = issue ? base_q + {i_q[AW-2:0], 1'b0} : '0;
    assign addrb     = issue ? base_q + {i_q[AW-2:0], 1'b1} : '0;
    assign out_valid = (cnt_q != 3'd0);
    assign {out_a, out_b, out_last} = mem_q[rp_q];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // Job sequencing: latch on start, step the pair index per issue, finish when the last pair leaves
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        n_d     = n_q;
        i_d     = i_q;
        done_d  = 1'b0;
        if (state_q == IDLE && start) begin
            if (pair_count == '0) begin
                done_d = 1'b1;
            end else begin
                state_d = RUN;
                base_d  = base_addr;
                n_d     = pair_count;
                i_d     = '0;
            end
        end else if (state_q == RUN && issue) begin
            i_d     = i_q + AW'(1);
            state_d = iss_last ? DRAIN : RUN;
        end else if (state_q == DRAIN && pop && out_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            n_q     <= '0;
            i_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            n_q     <= n_d;
            i_q     <= i_d;
            done_q  <= done_d;
        end
    end

    // Read-latency valid pipe and the 4-entry fall-through FIFO it feeds
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            l_q   <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int k = 0; k < 4; k++) mem_q[k] <= '0;
        end else begin
            v_q   <= {v_q[0], issue};
            l_q   <= {l_q[0], issue & iss_last};
            cnt_q <= cnt_q + 3'(push) - 3'(pop);
            if (push) begin
                mem_q[wp_q] <= {douta, doutb, l_q[1]};
                wp_q        <= wp_q + 2'd1;
            end
            if (pop) rp_q <= rp_q + 2'd1;
        end
    end
endmodule

// File: tb/tb_pwm_stream_reader.sv
// tb_pwm_stream_reader: directed checks of pair streaming, back-pressure, wrap, zero length, reset and ignored start
module tb_pwm_stream_reader;
    localparam int W = 16;
    localparam int D = 512;

    logic          clk = 1'b0;
    logic          rst, start, out_ready;
    logic [8:0]    base_addr, pair_count;
    logic          ena, enb, wea, web, out_valid, out_last, busy, done;
    logic [8:0]    addra, addrb;
    logic [W-1:0]  douta = '0, doutb = '0, out_a, out_b;

    pwm_stream_reader #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .pair_count(pair_count),
        .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
        .douta(douta), .doutb(doutb), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Bank model: word k holds k, data appears two cycles after the issuing cycle
    logic [W-1:0] bank [D];
    logic [8:0]   ra = '0, rb = '0;
    always @(posedge clk) begin
        if (ena) ra <= addra;
        if (enb) rb <= addrb;
        douta <= bank[ra];
        doutb <= bank[rb];
    end

    int n_chk = 0, n_pass = 0;
    int iss_n, pop_n, done_n, done_cyc, ov_n, busy_n, viol, hold_viol, stall_n;
    logic [8:0]  ia_q[$], ib_q[$];
    logic [15:0] pa_q[$], pb_q[$];
    logic        pl_q[$];
    int          pc_q[$];
    logic        busy_at [64];
    logic [57:0] rst_snap;
    logic        hold_prev;
    logic [32:0] hold_val;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [57:0] outs();
        return {ena, enb, wea, web, addra, addrb, out_valid, out_a, out_b, out_last, busy, done};
    endfunction

    function automatic logic ready_at(input int c);
        int m;
        m = (c - 1) % 4;
        return (m == 0) || (m == 3);
    endfunction

    task automatic sample(input int c);
        if (ena) begin
            if (iss_n - pop_n >= 4) viol++;
            if (!enb) viol++;
            iss_n++;
            ia_q.push_back(addra);
            ib_q.push_back(addrb);
        end
        if (wea || web) viol++;
        if (hold_prev) begin
            stall_n++;
            if ({out_valid, out_a, out_b, out_last} != {1'b1, hold_val}) hold_viol++;
        end
        hold_prev = out_valid && !out_ready;
        hold_val  = {out_a, out_b, out_last};
        if (out_valid && out_ready) begin
            pa_q.push_back(out_a);
            pb_q.push_back(out_b);
            pl_q.push_back(out_last);
            pc_q.push_back(c);
            pop_n++;
        end
        if (out_valid) ov_n++;
        if (busy) busy_n++;
        if (c < 64) busy_at[c] = busy;
        if (done) begin
            done_n++;
            done_cyc = c;
        end
    endtask

    task automatic run_job(input logic [8:0] b, input logic [8:0] n, input bit bp,
                           input int ncyc, input int s2, input int rc);
        iss_n = 0; pop_n = 0; done_n = 0; done_cyc = -1; ov_n = 0; busy_n = 0;
        viol = 0; hold_viol = 0; stall_n = 0; hold_prev = 1'b0; hold_val = '0;
        ia_q.delete(); ib_q.delete(); pa_q.delete(); pb_q.delete(); pl_q.delete(); pc_q.delete();
        for (int k = 0; k < 64; k++) busy_at[k] = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; pair_count = n; out_ready = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start = (c == s2);
            if (c == s2) begin
                base_addr  = 9'd200;
                pair_count = 9'd6;
            end
            rst = (c == rc);
            out_ready = bp ? ready_at(c) : 1'b1;
            @(negedge clk);
            if (c == rc + 1) rst_snap = outs();
            sample(c);
        end
    endtask

    task automatic check_pairs(input int n, input logic [8:0] b);
        logic [8:0] ea, eb;
        check("pair_count", pop_n, n);
        for (int i = 0; i < n && i < pa_q.size(); i++) begin
            ea = b + 9'(2 * i);
            eb = ea + 9'd1;
            check("pair_data", {pa_q[i], pb_q[i]}, {7'b0, ea, 7'b0, eb});
            check("pair_last", pl_q[i], (i == n - 1));
        end
    endtask

    initial begin
        for (int k = 0; k < D; k++) bank[k] = 16'(k);
        rst = 1'b1; start = 1'b0; base_addr = '0; pair_count = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outs", outs(), 0);

        run_job(9'd0, 9'd4, 1'b0, 20, -1, -1);
        check_pairs(4, 9'd0);
        for (int i = 0; i < 4 && i < pc_q.size(); i++) check("basic_cycle", pc_q[i], 4 + i);
        check("basic_done_cyc", done_cyc, 8);
        check("basic_done_n", done_n, 1);
        check("basic_issues", iss_n, 4);
        check("basic_busy1", busy_at[1], 1);
        check("basic_busy7", busy_at[7], 1);
        check("basic_busy8", busy_at[8], 0);

        run_job(9'd0, 9'd8, 1'b1, 50, -1, -1);
        check_pairs(8, 9'd0);
        check("bp_credit", viol, 0);
        check("bp_hold", hold_viol, 0);
        check("bp_stalled", stall_n > 0, 1);
        check("bp_done_n", done_n, 1);

        run_job(9'd510, 9'd2, 1'b0, 20, -1, -1);
        check("wrap_issues", iss_n, 2);
        if (ia_q.size() == 2) begin
            check("wrap_addr0", {ia_q[0], ib_q[0]}, {9'd510, 9'd511});
            check("wrap_addr1", {ia_q[1], ib_q[1]}, {9'd0, 9'd1});
        end
        check_pairs(2, 9'd510);

        run_job(9'd0, 9'd0, 1'b0, 10, -1, -1);
        check("zero_done_cyc", done_cyc, 1);
        check("zero_done_n", done_n, 1);
        check("zero_issues", iss_n, 0);
        check("zero_valid", ov_n, 0);
        check("zero_busy", busy_n, 0);

        run_job(9'd0, 9'd16, 1'b0, 12, -1, 6);
        check("midrst_outs", rst_snap, 0);
        run_job(9'd100, 9'd2, 1'b0, 20, -1, -1);
        check_pairs(2, 9'd100);
        check("postrst_done_cyc", done_cyc, 6);
        check("postrst_done_n", done_n, 1);

        run_job(9'd0, 9'd4, 1'b0, 30, 3, -1);
        check_pairs(4, 9'd0);
        check("busy_start_done_n", done_n, 1);
        check("busy_start_done_cyc", done_cyc, 8);
        check("busy_start_issues", iss_n, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pwm_stream_reader.md
# pwm_stream_reader

Streams coefficient pairs out of a two-port coefficient bank (the 2-cycle-read dpram) into the downstream pointwise-multiply / butterfly pipeline. Port A fetches even addresses and port B the following odd address of each pair. A credit-limited 4-entry FIFO absorbs the bank's fixed read latency, so the block sustains one pair per cycle and honours back-pressure without losing reads.

## Interface
- WIDTH, 16, coefficient width; matches the bank's WIDTH.
- DEPTH, 512, bank depth in words; matches the bank's DEPTH; power of two.
- AW (localparam), $clog2(DEPTH).

Ports:
- clk  in  1  rising-edge clock; the single clock of the block.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  AW  address of the first word; latched on accepted start.
- pair_count  in  AW  number of pairs to stream; latched on accepted start; 0 is legal.
- ena, enb  out  1  bank port enables.
- wea, web  out  1  bank write enables; tied 0.
- addra, addrb  out  AW  bank addresses.
- douta, doutb  in  WIDTH  bank read data; valid 2 cycles after the issuing cycle.
- out_valid  out  1  a pair is presented.
- out_ready  in  1  downstream accepts; transfer happens when out_valid & out_ready.
- out_a, out_b  out  WIDTH  even and odd coefficient of the pair.
- out_last  out  1  marks the final pair of the job.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at job end.

## Operation
- States:
  - IDLE: waits for start. On start with pair_count≠0, latches the job and goes to RUN. On start with pair_count=0, pulses done next cycle with no reads issued and stays in IDLE.
  - RUN: issues reads and goes to DRAIN once the last pair is issued.
  - DRAIN: waits until in-flight reads = 0, the FIFO is empty, and the last pair has transferred; then asserts done for one cycle and returns to IDLE.
- Issue rule: in RUN, a read issues (ena=enb=1) iff fifo_count + inflight < 4.
  - addra = base + 2·i and addrb = base + 2·i + 1, both modulo DEPTH (natural AW-bit wrap), for i = 0..pair_count−1.
  - ena/enb are 0 in all non-issuing cycles.
- Latency tracking: a 2-stage valid shift register follows each issue. A stage-2 valid pushes {douta, doutb, last} into the FIFO in that cycle. The inflight count equals the number of set valid bits.
- FIFO: 4 entries, first-word fall-through at the output register.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - By the credit rule the FIFO can never overflow; overflow is a design error, and the bench asserts it never occurs.
- out_last is carried with the entry for i = pair_count−1.
- start during busy is ignored; the latched job is unaffected.
- Reset: FSM to IDLE; FIFO, counters and valid pipe cleared.
  - Reads still in flight at reset are discarded, because their valid bits are cleared.
  - All outputs are 0 after reset: ena, enb, wea, web, addra, addrb, out_valid, out_a, out_b, out_last, busy, done.

## Timing
- Start accepted at cycle 0 → first issue (ena=1) at cycle 1 → data on douta at cycle 3, pushed at the end of cycle 3 → out_valid=1 at cycle 4.
- With out_ready held high: one pair per cycle. Pair i is presented at cycle 4+i; the last pair at cycle 3+N; done at cycle 4+N; busy falls at cycle 4+N.
- With out_ready low: issue stops once fifo_count + inflight reaches 4. At most 4 pairs are buffered. When out_ready returns, output resumes in the same cycle and issue resumes the following cycle.
- pair_count=0: done at cycle 1; busy stays 0.
- out_a, out_b and out_last are held stable while out_valid & !out_ready.

## Test plan
- Basic: bank word k = k, base=0, N=4, out_ready=1 → pairs (0,1),(2,3),(4,5),(6,7) at cycles 4–7, out_last at cycle 7, done at cycle 8, exactly 4 issue cycles.
- Back-pressure: N=8, out_ready toggles 1,0,0,1 repeating → all 8 pairs in order with no loss or duplication, ena never high when fifo_count + inflight = 4, and a held pair unchanged while stalled.
- Wrap: DEPTH=512, base=510, N=2 → issued addresses (510,511) then (0,1); outputs (510,511),(0,1).
- Zero length: start with N=0 → done pulse at cycle 1, ena never asserted, out_valid stays 0.
- Reset mid-job: N=16, assert rst at cycle 6 with reads in flight → the next cycle has every output 0. A new job (base=100, N=2) then yields only (100,101),(102,103), with no stale data.
- Start while busy: second start at cycle 3 with different base and N → ignored; the first job completes unchanged and a single done pulse occurs.
